prbs_stream_ctrl: RTL

Run controller for the 512-bit PRBS31 pattern generator on the cable-test transmit path. It reseeds the generator at the start of each run and frames its free-running output into AXI-Stream packets of programmable length, count and inter-packet gap. It reports progress and link stalls to the control/status registers. The generator has no enable, so the controller treats downstream backpressure as a test failure and aborts the run cleanly rather than silently dropping pattern words.

---
 rtl/prbs_ctrl_pkg.sv | 16 +
 rtl/prbs_stream_ctrl_if.sv | 12 +
 rtl/prbs_ctrl_counter.sv | 34 +++
 rtl/prbs_stream_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/prbs_ctrl_pkg.sv
// Shared types and timing constants for the PRBS stream run controller.
package prbs_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_PRIME,
    ST_SEND,
    ST_GAP,
    ST_HOLD
  } state_e;

  localparam int SEED_CYCLES  = 2;
  localparam int PRIME_CYCLES = 1;

endpackage

// File: rtl/prbs_stream_ctrl_if.sv
// AXI-Stream bundle between the run controller and the transmit path.
interface prbs_stream_ctrl_if #(
  parameter int DATA_W = 512
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/prbs_ctrl_counter.sv
// Loadable down-counter with zero flag; used for beat, gap and seed/prime timing.
module prbs_ctrl_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/prbs_stream_ctrl.sv
// Run controller: reseeds the PRBS generator and frames its output into AXI-Stream packets.
//
// state | meaning
// IDLE  | no run; generator free-running, waiting for start
// SEED  | generator held in reset for SEED_CYCLES
// PRIME | generator released; its first word appears on gen_value
// SEND  | streaming one beat per accepted cycle
// GAP   | idle cycles between packets
// HOLD  | downstream stalled; beat frozen as a truncated final beat
module prbs_stream_ctrl
  import prbs_ctrl_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int LEN_W  = 16,
  parameter int CNT_W  = 32,
  parameter int GAP_W  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [LEN_W-1:0]      cfg_beats,
  input  logic [CNT_W-1:0]      cfg_packets,
  input  logic [GAP_W-1:0]      cfg_gap,
  output logic                  gen_resetn,
  input  logic [DATA_W-1:0]     gen_value,
  prbs_stream_ctrl_if.master    m_axis,
  output logic                  busy,
  output logic                  done,
  output logic                  err_stall,
  output logic [CNT_W-1:0]      packets_sent
);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  tdata_q, tdata_d;
  logic               done_q, done_d;
  logic               err_stall_q, err_stall_d;
  logic [CNT_W-1:0]   pkts_q, pkts_d;
  logic               stop_pend_q, stop_pend_d;
  logic [LEN_W-1:0]   beats_cfg_q, beats_cfg_d;
  logic [CNT_W-1:0]   pkts_cfg_q, pkts_cfg_d;
  logic [GAP_W-1:0]   gap_cfg_q, gap_cfg_d;

  logic               beat_load, beat_dec, beat_zero;
  logic [LEN_W-1:0]   beat_load_val;
  logic               gap_load, gap_dec, gap_zero;
  logic [GAP_W-1:0]   gap_load_val;

  logic [CNT_W-1:0]   pkts_inc;
  logic               last_pkt;
  logic               stop_any;

  // Beat counter holds beats remaining after the one on the bus; zero marks tlast.
  assign beat_load_val = (beats_cfg_q == '0) ? '0 : beats_cfg_q - LEN_W'(1);
  assign pkts_inc      = pkts_q + CNT_W'(1);
  assign last_pkt      = (pkts_cfg_q != '0) && (pkts_inc == pkts_cfg_q);
  assign stop_any      = stop_pend_q | stop;

  prbs_ctrl_counter #(.W(LEN_W)) u_beat_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (beat_load),
    .load_val (beat_load_val),
    .dec      (beat_dec),
    .zero     (beat_zero)
  );

  prbs_ctrl_counter #(.W(GAP_W)) u_gap_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (gap_load),
    .load_val (gap_load_val),
    .dec      (gap_dec),
    .zero     (gap_zero)
  );

  always_comb begin
    state_d      = state_q;
    tdata_d      = tdata_q;
    done_d       = 1'b0;
    err_stall_d  = err_stall_q;
    pkts_d       = pkts_q;
    stop_pend_d  = stop_pend_q | (stop & (state_q != ST_IDLE));
    beats_cfg_d  = beats_cfg_q;
    pkts_cfg_d   = pkts_cfg_q;
    gap_cfg_d    = gap_cfg_q;
    beat_load    = 1'b0;
    beat_dec     = 1'b0;
    gap_load     = 1'b0;
    gap_dec      = 1'b0;
    gap_load_val = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_SEED;
          beats_cfg_d  = cfg_beats;
          pkts_cfg_d   = cfg_packets;
          gap_cfg_d    = cfg_gap;
          pkts_d       = '0;
          err_stall_d  = 1'b0;
          stop_pend_d  = 1'b0;
          gap_load     = 1'b1;
          gap_load_val = GAP_W'(SEED_CYCLES - 1);
        end
      end
      ST_SEED: begin
        if (gap_zero) begin
          state_d      = ST_PRIME;
          gap_load     = 1'b1;
          gap_load_val = GAP_W'(PRIME_CYCLES - 1);
        end else begin
          gap_dec = 1'b1;
        end
      end
      ST_PRIME: begin
        if (gap_zero) begin
          state_d   = ST_SEND;
          tdata_d   = gen_value;
          beat_load = 1'b1;
        end else begin
          gap_dec = 1'b1;
        end
      end
      ST_SEND: begin
        if (!m_axis.tready) begin
          state_d = ST_HOLD;
        end else if (!beat_zero) begin
          tdata_d  = gen_value;
          beat_dec = 1'b1;
        end else begin
          pkts_d = pkts_inc;
          if (last_pkt || stop_any) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (gap_cfg_q != '0) begin
            state_d      = ST_GAP;
            gap_load     = 1'b1;
            gap_load_val = gap_cfg_q - GAP_W'(1);
          end else begin
            tdata_d   = gen_value;
            beat_load = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (stop_any) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (gap_zero) begin
          state_d   = ST_SEND;
          tdata_d   = gen_value;
          beat_load = 1'b1;
        end else begin
          gap_dec = 1'b1;
        end
      end
      ST_HOLD: begin
        // The stalled beat goes out as a truncated packet, then the run aborts.
        if (m_axis.tready) begin
          state_d     = ST_IDLE;
          err_stall_d = 1'b1;
          pkts_d      = pkts_inc;
          done_d      = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tdata_q     <= '0;
      done_q      <= 1'b0;
      err_stall_q <= 1'b0;
      pkts_q      <= '0;
      stop_pend_q <= 1'b0;
      beats_cfg_q <= '0;
      pkts_cfg_q  <= '0;
      gap_cfg_q   <= '0;
    end else begin
      state_q     <= state_d;
      tdata_q     <= tdata_d;
      done_q      <= done_d;
      err_stall_q <= err_stall_d;
      pkts_q      <= pkts_d;
      stop_pend_q <= stop_pend_d;
      beats_cfg_q <= beats_cfg_d;
      pkts_cfg_q  <= pkts_cfg_d;
      gap_cfg_q   <= gap_cfg_d;
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = (state_q == ST_SEND) || (state_q == ST_HOLD);
  assign m_axis.tlast  = (state_q == ST_HOLD) || ((state_q == ST_SEND) && beat_zero);
  assign gen_resetn    = !reset && (state_q != ST_SEED);
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign err_stall     = err_stall_q;
  assign packets_sent  = pkts_q;

endmodule
